// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, iteration count,
// and the DIV_ZERO_FAST_EN build option (divide-by-zero skips the CALC loop).
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DIV_CYCLES = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_CYCLES);

`ifdef DIV_ZERO_FAST_EN
  localparam bit DIV_ZERO_FAST = 1'b1;
`else
  localparam bit DIV_ZERO_FAST = 1'b0;
`endif

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring step on the {rem, quo} pair: shift left, trial-subtract,
// keep the difference and set the quotient bit when it does not go negative.
module div_unit_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // rem < divisor always holds, so bit W of the W+1-bit trial is the borrow.
  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[W]) begin
      rem_o = trial[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = shifted[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit feeding HI (remainder) and LO (quotient); ready_o is the
// HI/LO write enable. Build option DIV_ZERO_FAST_EN: divide-by-zero finishes in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_CYCLES - 1);

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic en);
    return en ? (~x + DATA_W'(1)) : x;
  endfunction

  div_state_e            state_q;
  logic [DIV_CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0]     rem_q;
  logic [DATA_W-1:0]     quo_q;
  logic [DATA_W-1:0]     dvs_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic                  busy_q;
  logic                  ready_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;

  logic [DATA_W-1:0]     step_rem;
  logic [DATA_W-1:0]     step_quo;
  logic [DATA_W-1:0]     hi_d;
  logic [DATA_W-1:0]     lo_d;
  logic                  dividend_neg;
  logic                  divisor_neg;
  logic                  fast_zero;
  logic [DATA_W-1:0]     zero_lo;
  logic                  accept;

  div_unit_step #(.W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign accept       = start_i && !annul_i;
  assign dividend_neg = signed_i && dividend_i[DATA_W-1];
  assign divisor_neg  = signed_i && divisor_i[DATA_W-1];
  assign fast_zero    = DIV_ZERO_FAST && (divisor_i == '0);
  // Same value the loop converges to for a zero divisor: all-ones quotient, sign-fixed.
  assign zero_lo      = dividend_neg ? DATA_W'(1) : '1;

  // Sign fix applied on the final step, so the result lands in HI/LO in one edge.
  assign hi_d = cond_neg(step_rem, neg_rem_q);
  assign lo_d = cond_neg(step_quo, neg_quo_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          ready_q <= 1'b0;
          if (accept) begin
            if (fast_zero) begin
              state_q <= DIV_DONE;
              ready_q <= 1'b1;
              hi_q    <= dividend_i;
              lo_q    <= zero_lo;
            end else begin
              state_q   <= DIV_CALC;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              rem_q     <= '0;
              quo_q     <= cond_neg(dividend_i, dividend_neg);
              dvs_q     <= cond_neg(divisor_i, divisor_neg);
              neg_quo_q <= dividend_neg ^ divisor_neg;
              neg_rem_q <= dividend_neg;
            end
          end
        end

        DIV_CALC: begin
          if (annul_i) begin
            state_q <= DIV_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + DIV_CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_q <= DIV_DONE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              hi_q    <= hi_d;
              lo_q    <= lo_d;
            end
          end
        end

        DIV_DONE: begin
          state_q <= DIV_IDLE;
          ready_q <= 1'b0;
        end

        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases with literal results plus
// randomized per-cycle stimulus compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int ZLAT = FAST ? 1 : 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        busy_o, ready_o;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural result: truncating division, remainder takes dividend sign.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      r = a;
      q = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  // Timeline model: accepted start -> 32 busy cycles -> one ready cycle.
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_qp = '0, m_rp = '0;
  int          m_left = 0;

  always @(posedge clk) begin : model_p
    logic [31:0] q, r;
    if (rst) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_left  <= 0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
    end else if (m_busy) begin
      if (annul_i) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_hi    <= m_rp;
        m_lo    <= m_qp;
        m_left  <= 0;
      end else m_left <= m_left - 1;
    end else if (start_i && !annul_i) begin
      ref_div(signed_i, dividend_i, divisor_i, q, r);
      if (FAST && divisor_i == 32'd0) begin
        m_ready <= 1'b1;
        m_hi    <= r;
        m_lo    <= q;
      end else begin
        m_busy <= 1'b1;
        m_left <= 32;
        m_qp   <= q;
        m_rp   <= r;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_busy", {31'd0, busy_o}, {31'd0, m_busy});
      check("cyc_ready", {31'd0, ready_o}, {31'd0, m_ready});
      check("cyc_hi", hi_o, m_hi);
      check("cyc_lo", lo_o, m_lo);
    end
  end

  // Called just after a negedge; returns just after the negedge following ready.
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input int exp_lat);
    int n, nbusy;
    logic [31:0] q, r;
    ref_div(sgn, a, b, q, r);
    check({name, "_model_lo"}, q, exp_lo);
    check({name, "_model_hi"}, r, exp_hi);
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    @(negedge clk);
    start_i = 1'b0;
    n = 1; nbusy = 0;
    while (!ready_o && n < 40) begin
      if (busy_o) nbusy++;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_busy_cycles"}, nbusy, (exp_lat == 1) ? 0 : 32);
    check({name, "_lo"}, lo_o, exp_lo);
    check({name, "_hi"}, hi_o, exp_hi);
    $display("op %s: %h / %h signed=%0d -> lo=%h hi=%h lat=%0d", name, a, b, sgn, lo_o, hi_o, n);
    @(negedge clk);
  endtask

  initial begin
    int n, nready;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);

    run_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 33);
    run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_op("sdiv_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 33);
    run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
    run_op("sdiv_zero", 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h0000_0001, 32'hFFFF_FFF0, ZLAT);
    run_op("udiv_zero", 1'b0, 32'h0000_0005, 32'h0, 32'hFFFF_FFFF, 32'h0000_0005, ZLAT);
    run_op("sdiv_zero_min", 1'b1, 32'h8000_0000, 32'h0, 32'h0000_0001, 32'h8000_0000, ZLAT);

    // Annul at CALC cycle 10, then an immediate new start.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd10;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_busy", {31'd0, busy_o}, 32'd0);
    check("annul_hold_lo", lo_o, 32'h0000_0001);
    check("annul_hold_hi", hi_o, 32'h8000_0000);
    run_op("after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Start toggled while busy must not re-latch operands.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd7;
    @(negedge clk);
    n = 1;
    while (!ready_o && n < 40) begin
      start_i = n[0]; signed_i = 1'b1; dividend_i = $urandom; divisor_i = 32'd5;
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    check("busy_start_latency", n, 33);
    check("busy_start_lo", lo_o, 32'd142);
    check("busy_start_hi", hi_o, 32'd6);
    @(negedge clk);

    // Reset mid-CALC with start toggling while busy.
    start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'hFFFF_FF00; divisor_i = 32'd3;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start_i = i[0]; dividend_i = $urandom;
      @(negedge clk);
    end
    start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_ready", {31'd0, ready_o}, 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    nready = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) nready++;
    end
    check("midrst_no_ready", nready, 0);

    // Randomized per-cycle stimulus; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a, b;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 100);
        2: a = 32'hFFFF_FFFF - $urandom_range(0, 100);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = $urandom_range(2, 50);
        4: b = 32'hFFFF_FFFF - $urandom_range(0, 50);
        default: b = $urandom;
      endcase
      start_i    = ($urandom_range(0, 3) == 0);
      signed_i   = $urandom_range(0, 1) == 1;
      dividend_i = a;
      divisor_i  = b;
      annul_i    = ($urandom_range(0, 47) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    start_i = 1'b0; annul_i = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
